// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// the clear/run state type and a size-legality helper.
package dm_pkg;

    localparam logic [2:0] LS_B       = 3'b001;
    localparam logic [2:0] LS_H       = 3'b010;
    localparam logic [2:0] LS_W       = 3'b100;
    localparam int         LS_UNS_BIT = 3;

    typedef enum logic {
        DM_CLEAR,
        DM_RUN
    } dm_state_t;

    // Only the three one-hot size codes describe a real access.
    function automatic logic is_legal_size(input logic [2:0] size);
        return (size == LS_B) || (size == LS_H) || (size == LS_W);
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering between the core and one 32-bit memory word.
// Store side: size + lane -> byte enables and lane-replicated store data.
// Load side: stored word + size + lane -> aligned, extended load data.
// A misaligned or illegal-size access yields no byte enables and zero data.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [3:0]  i_ls,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_illegal
);

    logic [2:0]  w_size;
    logic        w_uns;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_size = i_ls[2:0];
    assign w_uns  = i_ls[LS_UNS_BIT];

    // Decode size/lane into enables, replicated store data and extended load data.
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = i_wdata;
        o_rdata    = 32'h0;
        o_illegal  = !is_legal_size(w_size);
        o_misalign = ((w_size == LS_H) && i_lane[0]) ||
                     ((w_size == LS_W) && (i_lane != 2'b00));
        w_byte     = i_word[8*i_lane +: 8];
        w_half     = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (w_size)
            LS_B: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = w_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            LS_H: begin
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = w_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            end
            LS_W: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_word;
            end
            default: begin
                o_be    = 4'b0000;
                o_rdata = 32'h0;
            end
        endcase
        if (o_misalign) begin
            o_be    = 4'b0000;
            o_rdata = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's MEM-stage data port.
// Word array with byte-lane stores, combinational aligned loads, a sticky
// misalignment/illegal-access fault latch and optional perf counters
// (enabled with `DM_PERF_CNT_EN; otherwise load_cnt/store_cnt read 0).
//
// state    | meaning
// DM_CLEAR | zeroing word r_clr_idx each cycle, accesses ignored, ready=0
// DM_RUN   | array live, ready=1, left only through rst
module dmem_responder
    import dm_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [3:0]  ls,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt
);

    logic [31:0]   r_mem [DEPTH];
    dm_state_t     r_state;
    logic [AW-1:0] r_clr_idx;
    logic          r_ready;
    logic          r_fault;
    logic [31:0]   r_fault_addr;

    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_rdata;
    logic          w_misalign;
    logic          w_illegal;
    logic          w_bad;
    logic          w_fault_evt;
    logic          w_store;
    logic          w_unused;

    // Upper address bits alias: the array wraps modulo DEPTH*4 bytes.
    assign w_idx    = addr[AW+1:2];
    assign w_unused = ^addr[31:AW+2];
    assign w_word   = r_mem[w_idx];

    dm_lane_align u_align (
        .i_ls       (ls),
        .i_lane     (addr[1:0]),
        .i_wdata    (wdata),
        .i_word     (w_word),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_rdata),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    assign w_bad       = w_misalign | w_illegal;
    assign w_fault_evt = (mem_write | mem_read) & r_ready & w_bad;
    assign w_store     = r_ready & mem_write & !w_bad;

    assign readdata   = (r_ready && !w_bad) ? w_rdata : 32'h0;
    assign ready      = r_ready;
    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;

    // Array write port: clear sweep has priority, then byte-enabled stores.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == DM_CLEAR) begin
                r_mem[r_clr_idx] <= 32'h0;
            end else if (w_store) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                    end
                end
            end
        end
    end

    // Clear sequencer: DEPTH cycles of zeroing after reset, then run forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DM_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                DM_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == AW'(DEPTH - 1)) begin
                        r_state <= DM_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= DM_RUN;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Sticky fault flag; only the first faulting address is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault      <= 1'b0;
            r_fault_addr <= 32'h0;
        end else if (w_fault_evt) begin
            r_fault <= 1'b1;
            if (!r_fault) begin
                r_fault_addr <= addr;
            end
        end
    end

`ifdef DM_PERF_CNT_EN
    logic [31:0] r_load_cnt;
    logic [31:0] r_store_cnt;

    // Perf counters: clean loads and committed stores, free-running wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_cnt  <= 32'h0;
            r_store_cnt <= 32'h0;
        end else begin
            if (r_ready && mem_read && !mem_write && !w_fault_evt) begin
                r_load_cnt <= r_load_cnt + 32'd1;
            end
            if (w_store) begin
                r_store_cnt <= r_store_cnt + 32'd1;
            end
        end
    end

    assign load_cnt  = r_load_cnt;
    assign store_cnt = r_store_cnt;
`else
    assign load_cnt  = 32'h0;
    assign store_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder with a byte-level
// reference model of the memory, fault latch and perf counters.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
    logic [3:0]  ls;
    logic [31:0] readdata;
    logic        ready;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_ready;
    bit          m_fault;
    logic [31:0] m_faddr;
    logic [31:0] m_lcnt;
    logic [31:0] m_scnt;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .ls         (ls),
        .readdata   (readdata),
        .ready      (ready),
        .fault      (fault),
        .fault_addr (fault_addr),
        .load_cnt   (load_cnt),
        .store_cnt  (store_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [3:0] l);
        case (l[2:0])
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_bad(input logic [31:0] a, input logic [3:0] l);
        int sz = size_bytes(l);
        if (sz == 0) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [3:0] l);
        int          sz  = size_bytes(l);
        int          idx = (a / 4) % DEPTH;
        int          sh  = 8 * (a % 4);
        logic [31:0] v;
        if (!m_ready || is_bad(a, l)) return 32'h0;
        if (sz == 4) return m_mem[idx];
        v = (m_mem[idx] >> sh) & ((sz == 1) ? 32'hFF : 32'hFFFF);
        if (!l[3]) begin
            if (sz == 1 && v >= 32'h80)   v = v - 32'h100;
            if (sz == 2 && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_ready = 1'b0;
        m_fault = 1'b0;
        m_faddr = 32'h0;
        m_lcnt  = 32'h0;
        m_scnt  = 32'h0;
    endtask

    function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef DM_PERF_CNT_EN
        return c;
`else
        return 32'h0 & c;
`endif
    endfunction

    // One access cycle: drive, check combinational/state outputs, advance model.
    task automatic do_op(input bit mw, input bit mr, input logic [3:0] l,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd_obs);
        int          sz, idx, sh;
        logic [31:0] mask;
        bit          bad, evt;
        mem_write = mw;
        mem_read  = mr;
        ls        = l;
        addr      = a;
        wdata     = wd;
        @(negedge clk);
        rd_obs = readdata;
        check("readdata", readdata, exp_read(a, l));
        check("ready", 32'(ready), 32'(m_ready));
        check("fault", 32'(fault), 32'(m_fault));
        check("fault_addr", fault_addr, m_faddr);
        check("load_cnt", load_cnt, exp_cnt(m_lcnt));
        check("store_cnt", store_cnt, exp_cnt(m_scnt));
        bad = is_bad(a, l);
        evt = (mw || mr) && m_ready && bad;
        if (evt) begin
            if (!m_fault) m_faddr = a;
            m_fault = 1'b1;
        end
        if (m_ready && mw && !bad) begin
            sz   = size_bytes(l);
            idx  = (a / 4) % DEPTH;
            sh   = 8 * (a % 4);
            mask = (sz == 4) ? 32'hFFFF_FFFF : (((sz == 1) ? 32'hFF : 32'hFFFF) << sh);
            m_mem[idx] = (m_mem[idx] & ~mask) | ((wd << sh) & mask);
            m_scnt++;
        end
        if (m_ready && mr && !mw && !evt) m_lcnt++;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    // Wait for the clear sweep; optionally issue one store during it.
    task automatic wait_clear(input int store_at);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 3 * DEPTH) begin
            if (n == store_at) begin
                mem_write = 1'b1; mem_read = 1'b0; ls = 4'b0100;
                addr = 32'h0; wdata = 32'hCAFE_F00D;
            end else begin
                mem_write = 1'b0; mem_read = 1'b1; ls = 4'b0100;
                addr = $urandom & 32'hFFFF_FFFC;
            end
            @(negedge clk);
            if (n % 128 == 0) check("clear_rdata", readdata, 32'h0);
            @(posedge clk);
            #1;
            n++;
            if (ready) done = 1'b1;
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;
        check("clear_len", 32'(n), 32'(DEPTH));
        m_ready = 1'b1;
    endtask

    logic [3:0] ls_tab [8];

    initial begin
        logic [31:0] rd;
        logic [31:0] base_l, base_s;
        ls_tab[0] = 4'b0001; ls_tab[1] = 4'b0010; ls_tab[2] = 4'b0100;
        ls_tab[3] = 4'b1001; ls_tab[4] = 4'b1010; ls_tab[5] = 4'b1100;
        ls_tab[6] = 4'b0011; ls_tab[7] = 4'b0000;

        rst = 1'b1; addr = 32'h0; wdata = 32'h0;
        mem_write = 1'b0; mem_read = 1'b0; ls = 4'b0100;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_faddr", fault_addr, 32'h0);
        check("rst_lcnt", load_cnt, 32'h0);
        check("rst_scnt", store_cnt, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: clear length and zeroed array
        wait_clear(-1);
        for (int i = 0; i < 6; i++) begin
            do_op(1'b0, 1'b1, 4'b0100, ($urandom % (DEPTH * 4)) & 32'hFFFF_FFFC, 32'h0, rd);
            check("t1_lw_zero", rd, 32'h0);
        end
        do_op(1'b0, 1'b1, 4'b0100, 32'h0000_0FFC, 32'h0, rd);
        check("t1_lw_last", rd, 32'h0);

        // 2: sign/zero extension
        do_op(1'b1, 1'b0, 4'b0100, 32'h10, 32'h80FF_7F01, rd);
        do_op(1'b0, 1'b1, 4'b0001, 32'h10, 32'h0, rd); check("t2_lb10", rd, 32'h0000_0001);
        do_op(1'b0, 1'b1, 4'b0001, 32'h13, 32'h0, rd); check("t2_lb13", rd, 32'hFFFF_FF80);
        do_op(1'b0, 1'b1, 4'b1001, 32'h13, 32'h0, rd); check("t2_lbu13", rd, 32'h0000_0080);
        do_op(1'b0, 1'b1, 4'b0010, 32'h12, 32'h0, rd); check("t2_lh12", rd, 32'hFFFF_80FF);
        do_op(1'b0, 1'b1, 4'b1010, 32'h12, 32'h0, rd); check("t2_lhu12", rd, 32'h0000_80FF);

        // 3: byte and half stores
        do_op(1'b1, 1'b0, 4'b0001, 32'h11, 32'h0000_00AA, rd);
        do_op(1'b1, 1'b0, 4'b0010, 32'h16, 32'h0000_1234, rd);
        do_op(1'b0, 1'b1, 4'b0100, 32'h10, 32'h0, rd); check("t3_lw10", rd, 32'h80FF_AA01);
        do_op(1'b0, 1'b1, 4'b0100, 32'h14, 32'h0, rd); check("t3_lw14", rd, 32'h1234_0000);

        // 4: misaligned store suppressed, first fault address kept
        do_op(1'b1, 1'b0, 4'b0100, 32'h12, 32'hDEAD_BEEF, rd);
        do_op(1'b0, 1'b1, 4'b0100, 32'h10, 32'h0, rd); check("t4_lw10", rd, 32'h80FF_AA01);
        check("t4_fault", 32'(fault), 32'h1);
        check("t4_faddr", fault_addr, 32'h12);
        do_op(1'b0, 1'b1, 4'b0010, 32'h21, 32'h0, rd); check("t4_lh21", rd, 32'h0);
        do_op(1'b0, 1'b0, 4'b0100, 32'h0, 32'h0, rd);
        check("t4_faddr_kept", fault_addr, 32'h12);

        // 6: perf counters
        base_l = m_lcnt;
        base_s = m_scnt;
        for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 4'b0100, 32'h40 + 4 * i, $urandom, rd);
        for (int i = 0; i < 5; i++) do_op(1'b0, 1'b1, 4'b0100, 32'h40 + 4 * i, 32'h0, rd);
        do_op(1'b0, 1'b1, 4'b0100, 32'h42, 32'h0, rd);
        do_op(1'b0, 1'b0, 4'b0100, 32'h0, 32'h0, rd);
        check("t6_store_cnt", store_cnt - exp_cnt(base_s), exp_cnt(32'd3));
        check("t6_load_cnt", load_cnt - exp_cnt(base_l), exp_cnt(32'd5));

        // randomized mix against the model, upper address bits scrambled
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            do_op(1'($urandom), 1'($urandom), ls_tab[$urandom_range(0, 7)], a, $urandom, rd);
        end
        do_op(1'b0, 1'b0, 4'b0100, 32'h0, 32'h0, rd);

        // 5: reset pulse mid-clear restarts the sweep; store during clear is lost
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        repeat (500) @(posedge clk);
        #1;
        check("t5_ready_mid", 32'(ready), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        wait_clear(100);
        do_op(1'b0, 1'b1, 4'b0100, 32'h0, 32'h0, rd); check("t5_lost_store", rd, 32'h0);
        do_op(1'b0, 1'b0, 4'b0100, 32'h0, 32'h0, rd);
        check("t5_no_fault", 32'(fault), 32'h0);
        check("t5_scnt", store_cnt, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
